// File: rtl/i2c_bus_conditioner_pkg.sv
// rtl/i2c_bus_conditioner_pkg.sv - START/STOP detection state codes shared by the I2C slave front end
package i2c_bus_conditioner_pkg;

    typedef enum logic [1:0] {
        NULL_DET  = 2'b00,
        START_DET = 2'b01,
        STOP_DET  = 2'b10
    } det_state_t;

endpackage

// File: rtl/i2c_bus_conditioner_line_filter.sv
// rtl/i2c_bus_conditioner_line_filter.sv - synchroniser plus debounce filter for one I2C pad line (idles high)
module i2c_line_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_LEN     = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic rawIn,
    output logic filtOut
);

    localparam int CW = (DEB_LEN > 1) ? $clog2(DEB_LEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rawIn};
        end
    end

    // The output only follows after DEB_LEN consecutive disagreeing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            filtOut <= 1'b1;
        end else if (synced == filtOut) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            filtOut <= ~filtOut;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/i2c_bus_conditioner.sv
// rtl/i2c_bus_conditioner.sv - filtered SCL/SDA, sticky START/STOP detection and bus-busy tracking
// Optional SCL-low bus timeout is enabled with `I2C_BUS_TIMEOUT_EN.
module i2c_bus_conditioner
    import i2c_bus_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_LEN     = 4
`ifdef I2C_BUS_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 50000
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclRaw,
    input  logic       sdaRaw,
    input  logic       clearStartStopDet,
    output logic       scl,
    output logic       sdaIn,
    output logic [1:0] startStopDetState,
    output logic       busBusy
`ifdef I2C_BUS_TIMEOUT_EN
    ,
    output logic       timeoutFlag
`endif
);

    det_state_t state_q, state_next;
    logic       busy_q, busy_next;
    logic       scl_d, sda_d;
    logic       start_cond, stop_cond;
    logic       timeout_hit;

    i2c_line_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .DEB_LEN    (DEB_LEN)
    ) u_scl_filter (
        .clk    (clk),
        .rst    (rst),
        .rawIn  (sclRaw),
        .filtOut(scl)
    );

    i2c_line_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .DEB_LEN    (DEB_LEN)
    ) u_sda_filter (
        .clk    (clk),
        .rst    (rst),
        .rawIn  (sdaRaw),
        .filtOut(sdaIn)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_d <= 1'b1;
            sda_d <= 1'b1;
        end else begin
            scl_d <= scl;
            sda_d <= sdaIn;
        end
    end

    // Requiring SCL high on both samples rejects SDA edges coincident with an SCL edge.
    assign start_cond = scl_d & scl & sda_d & ~sdaIn;
    assign stop_cond  = scl_d & scl & ~sda_d & sdaIn;

`ifdef I2C_BUS_TIMEOUT_EN
    logic [15:0] to_cnt_q;
    logic        timeout_next;

    assign timeout_hit = busy_q & ~scl & (to_cnt_q == 16'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_q <= '0;
        end else if (!busy_q || scl || timeout_hit) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + 16'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= NULL_DET;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_next;
            busy_q  <= busy_next;
        end
    end

    // Bus events take priority over clear so a detection is never dropped.
    always_comb begin
        state_next = state_q;
        busy_next  = busy_q;
        if (start_cond) begin
            state_next = START_DET;
            busy_next  = 1'b1;
        end else if (stop_cond || timeout_hit) begin
            state_next = STOP_DET;
            busy_next  = 1'b0;
        end else if (clearStartStopDet) begin
            state_next = NULL_DET;
        end
    end

`ifdef I2C_BUS_TIMEOUT_EN
    assign timeout_next = timeout_hit & ~start_cond & ~stop_cond;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeoutFlag <= 1'b0;
        end else begin
            timeoutFlag <= timeout_next;
        end
    end
`endif

    assign startStopDetState = state_q;
    assign busBusy           = busy_q;

endmodule

// File: tb/tb_i2c_bus_conditioner.sv
// tb/tb_i2c_bus_conditioner.sv - scoreboard bench for i2c_bus_conditioner (timeout checks with `I2C_BUS_TIMEOUT_EN)
module tb_i2c_bus_conditioner;

    localparam logic [1:0] NUL = 2'b00;
    localparam logic [1:0] STA = 2'b01;
    localparam logic [1:0] STO = 2'b10;

    logic       clk = 1'b0;
    logic       rst;
    logic       sclRaw;
    logic       sdaRaw;
    logic       clearStartStopDet;
    logic       scl;
    logic       sdaIn;
    logic [1:0] startStopDetState;
    logic       busBusy;
`ifdef I2C_BUS_TIMEOUT_EN
    logic       timeoutFlag;
`endif

    always #5 clk = ~clk;

    i2c_bus_conditioner #(
        .SYNC_STAGES(2),
        .DEB_LEN    (4)
`ifdef I2C_BUS_TIMEOUT_EN
        ,
        .TIMEOUT_CYC(100)
`endif
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .sclRaw           (sclRaw),
        .sdaRaw           (sdaRaw),
        .clearStartStopDet(clearStartStopDet),
        .scl              (scl),
        .sdaIn            (sdaIn),
        .startStopDetState(startStopDetState),
        .busBusy          (busBusy)
`ifdef I2C_BUS_TIMEOUT_EN
        ,
        .timeoutFlag      (timeoutFlag)
`endif
    );

    // One scoreboard entry: pad/clear levels to drive, clocks to wait, then the expected outputs.
    typedef struct {
        string      name;
        logic       scl_in;
        logic       sda_in;
        logic       clr;
        int         ticks;
        logic [1:0] st;
        logic       busy;
        logic       scl_o;
        logic       sda_o;
        logic       to;
    } step_t;

    step_t exp_q[$];
    step_t e;
    int    n_cmp = 0;
    int    n_err = 0;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input string nm, input logic si, input logic di, input logic c, input int t,
                        input logic [1:0] st, input logic b, input logic so, input logic dout,
                        input logic to = 1'b0);
        step_t s;
        s.name = nm; s.scl_in = si; s.sda_in = di; s.clr = c; s.ticks = t;
        s.st = st; s.busy = b; s.scl_o = so; s.sda_o = dout; s.to = to;
        exp_q.push_back(s);
    endtask

    task automatic test_reset();
        push("reset_idle", 1, 1, 0, 1, NUL, 0, 1, 1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            sclRaw = e.scl_in; sdaRaw = e.sda_in; clearStartStopDet = e.clr;
            tick(e.ticks);
            n_cmp++;
            if (startStopDetState !== e.st || busBusy !== e.busy || scl !== e.scl_o || sdaIn !== e.sda_o) begin
                n_err++;
                $display("FAIL %s: state=%0d busy=%0b scl=%0b sda=%0b required state=%0d busy=%0b scl=%0b sda=%0b",
                         e.name, startStopDetState, busBusy, scl, sdaIn, e.st, e.busy, e.scl_o, e.sda_o);
            end
        end
    endtask

    task automatic test_start_clear_stop();
        push("start_sda_pre",    1, 0, 0, 5, NUL, 0, 1, 1);
        push("start_sda_filt",   1, 0, 0, 1, NUL, 0, 1, 0);
        push("start_det",        1, 0, 0, 1, STA, 1, 1, 0);
        push("start_hold",       1, 0, 0, 3, STA, 1, 1, 0);
        push("start_scl_low",    0, 0, 0, 8, STA, 1, 0, 0);
        push("clear_pulse",      0, 0, 1, 1, NUL, 1, 0, 0);
        push("clear_release",    0, 0, 0, 1, NUL, 1, 0, 0);
        push("scl_rise_sda_low", 1, 0, 0, 8, NUL, 1, 1, 0);
        push("stop_pre",         1, 1, 0, 6, NUL, 1, 1, 1);
        push("stop_det",         1, 1, 0, 1, STO, 0, 1, 1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            sclRaw = e.scl_in; sdaRaw = e.sda_in; clearStartStopDet = e.clr;
            tick(e.ticks);
            n_cmp++;
            if (startStopDetState !== e.st || busBusy !== e.busy || scl !== e.scl_o || sdaIn !== e.sda_o) begin
                n_err++;
                $display("FAIL %s: state=%0d busy=%0b scl=%0b sda=%0b required state=%0d busy=%0b scl=%0b sda=%0b",
                         e.name, startStopDetState, busBusy, scl, sdaIn, e.st, e.busy, e.scl_o, e.sda_o);
            end
        end
    endtask

    task automatic test_glitch();
        push("glitch_clear",  1, 1, 1, 1,  NUL, 0, 1, 1);
        push("glitch3_low",   1, 0, 0, 3,  NUL, 0, 1, 1);
        push("glitch3_high",  1, 1, 0, 10, NUL, 0, 1, 1);
        push("pulse4_low",    1, 0, 0, 4,  NUL, 0, 1, 1);
        push("pulse4_high",   1, 1, 0, 2,  NUL, 0, 1, 0);
        push("pulse4_start",  1, 1, 0, 1,  STA, 1, 1, 0);
        push("pulse4_stop",   1, 1, 0, 4,  STO, 0, 1, 1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            sclRaw = e.scl_in; sdaRaw = e.sda_in; clearStartStopDet = e.clr;
            tick(e.ticks);
            n_cmp++;
            if (startStopDetState !== e.st || busBusy !== e.busy || scl !== e.scl_o || sdaIn !== e.sda_o) begin
                n_err++;
                $display("FAIL %s: state=%0d busy=%0b scl=%0b sda=%0b required state=%0d busy=%0b scl=%0b sda=%0b",
                         e.name, startStopDetState, busBusy, scl, sdaIn, e.st, e.busy, e.scl_o, e.sda_o);
            end
        end
    endtask

    task automatic test_clear_collision();
        push("col_start",    1, 0, 0, 7, STA, 1, 1, 0);
        push("col_stop_pre", 1, 1, 0, 6, STA, 1, 1, 1);
        push("col_stop_clr", 1, 1, 1, 1, STO, 0, 1, 1);
        push("col_hold_clr", 1, 1, 1, 3, NUL, 0, 1, 1);
        push("col_after",    1, 1, 0, 2, NUL, 0, 1, 1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            sclRaw = e.scl_in; sdaRaw = e.sda_in; clearStartStopDet = e.clr;
            tick(e.ticks);
            n_cmp++;
            if (startStopDetState !== e.st || busBusy !== e.busy || scl !== e.scl_o || sdaIn !== e.sda_o) begin
                n_err++;
                $display("FAIL %s: state=%0d busy=%0b scl=%0b sda=%0b required state=%0d busy=%0b scl=%0b sda=%0b",
                         e.name, startStopDetState, busBusy, scl, sdaIn, e.st, e.busy, e.scl_o, e.sda_o);
            end
        end
    endtask

    task automatic test_same_clk_and_repeated_start();
        push("same_fall",   0, 0, 0, 10, NUL, 0, 0, 0);
        push("same_rise",   1, 1, 0, 10, NUL, 0, 1, 1);
        push("rs_start",    1, 0, 0, 7,  STA, 1, 1, 0);
        push("rs_scl_low",  0, 0, 0, 8,  STA, 1, 0, 0);
        push("rs_sda_high", 0, 1, 0, 8,  STA, 1, 0, 1);
        push("rs_scl_high", 1, 1, 0, 8,  STA, 1, 1, 1);
        push("rs_restart",  1, 0, 0, 7,  STA, 1, 1, 0);
        push("rs_stop",     1, 1, 0, 7,  STO, 0, 1, 1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            sclRaw = e.scl_in; sdaRaw = e.sda_in; clearStartStopDet = e.clr;
            tick(e.ticks);
            n_cmp++;
            if (startStopDetState !== e.st || busBusy !== e.busy || scl !== e.scl_o || sdaIn !== e.sda_o) begin
                n_err++;
                $display("FAIL %s: state=%0d busy=%0b scl=%0b sda=%0b required state=%0d busy=%0b scl=%0b sda=%0b",
                         e.name, startStopDetState, busBusy, scl, sdaIn, e.st, e.busy, e.scl_o, e.sda_o);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            int gap;
            gap = $urandom_range(1, 6);
            push("b2b_idle",  1, 1, 1, 1,   NUL, 0, 1, 1);
            push("b2b_start", 1, 0, 0, 7,   STA, 1, 1, 0);
            push("b2b_hold",  1, 0, 0, gap, STA, 1, 1, 0);
            push("b2b_stop",  1, 1, 0, 7,   STO, 0, 1, 1);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            sclRaw = e.scl_in; sdaRaw = e.sda_in; clearStartStopDet = e.clr;
            tick(e.ticks);
            n_cmp++;
            if (startStopDetState !== e.st || busBusy !== e.busy || scl !== e.scl_o || sdaIn !== e.sda_o) begin
                n_err++;
                $display("FAIL %s: state=%0d busy=%0b scl=%0b sda=%0b required state=%0d busy=%0b scl=%0b sda=%0b",
                         e.name, startStopDetState, busBusy, scl, sdaIn, e.st, e.busy, e.scl_o, e.sda_o);
            end
        end
    endtask

    task automatic test_reset_mid();
        push("rm_start", 1, 0, 0, 7, STA, 1, 1, 0);
        push("rm_scl_low", 0, 0, 0, 3, STA, 1, 1, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            sclRaw = e.scl_in; sdaRaw = e.sda_in; clearStartStopDet = e.clr;
            tick(e.ticks);
            n_cmp++;
            if (startStopDetState !== e.st || busBusy !== e.busy || scl !== e.scl_o || sdaIn !== e.sda_o) begin
                n_err++;
                $display("FAIL %s: state=%0d busy=%0b scl=%0b sda=%0b required state=%0d busy=%0b scl=%0b sda=%0b",
                         e.name, startStopDetState, busBusy, scl, sdaIn, e.st, e.busy, e.scl_o, e.sda_o);
            end
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (startStopDetState !== NUL || busBusy !== 1'b0 || scl !== 1'b1 || sdaIn !== 1'b1) begin
            n_err++;
            $display("FAIL rm_async: state=%0d busy=%0b scl=%0b sda=%0b required state=0 busy=0 scl=1 sda=1",
                     startStopDetState, busBusy, scl, sdaIn);
        end
        sclRaw = 1'b1; sdaRaw = 1'b1;
        tick(3);
        rst = 1'b0;
        push("rm_release", 1, 1, 0, 10, NUL, 0, 1, 1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            sclRaw = e.scl_in; sdaRaw = e.sda_in; clearStartStopDet = e.clr;
            tick(e.ticks);
            n_cmp++;
            if (startStopDetState !== e.st || busBusy !== e.busy || scl !== e.scl_o || sdaIn !== e.sda_o) begin
                n_err++;
                $display("FAIL %s: state=%0d busy=%0b scl=%0b sda=%0b required state=%0d busy=%0b scl=%0b sda=%0b",
                         e.name, startStopDetState, busBusy, scl, sdaIn, e.st, e.busy, e.scl_o, e.sda_o);
            end
        end
    endtask

`ifdef I2C_BUS_TIMEOUT_EN
    task automatic test_timeout();
        push("to_start",    1, 0, 0, 7,   STA, 1, 1, 0, 0);
        push("to_pre",      0, 0, 0, 105, STA, 1, 0, 0, 0);
        push("to_fire",     0, 0, 0, 1,   STO, 0, 0, 0, 1);
        push("to_after",    0, 0, 0, 1,   STO, 0, 0, 0, 0);
        push("to_scl_up",   1, 0, 0, 8,   STO, 0, 1, 0, 0);
        push("to_sda_up",   1, 1, 0, 7,   STO, 0, 1, 1, 0);
        push("to_restart",  1, 0, 0, 7,   STA, 1, 1, 0, 0);
        push("to_midcount", 0, 0, 0, 50,  STA, 1, 0, 0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            sclRaw = e.scl_in; sdaRaw = e.sda_in; clearStartStopDet = e.clr;
            tick(e.ticks);
            n_cmp++;
            if (startStopDetState !== e.st || busBusy !== e.busy || scl !== e.scl_o || sdaIn !== e.sda_o ||
                timeoutFlag !== e.to) begin
                n_err++;
                $display("FAIL %s: state=%0d busy=%0b scl=%0b sda=%0b to=%0b required state=%0d busy=%0b scl=%0b sda=%0b to=%0b",
                         e.name, startStopDetState, busBusy, scl, sdaIn, timeoutFlag,
                         e.st, e.busy, e.scl_o, e.sda_o, e.to);
            end
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (startStopDetState !== NUL || busBusy !== 1'b0 || timeoutFlag !== 1'b0 || scl !== 1'b1) begin
            n_err++;
            $display("FAIL to_reset_mid: state=%0d busy=%0b to=%0b scl=%0b required state=0 busy=0 to=0 scl=1",
                     startStopDetState, busBusy, timeoutFlag, scl);
        end
        sclRaw = 1'b1; sdaRaw = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(2);
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        sclRaw = 1'b1;
        sdaRaw = 1'b1;
        clearStartStopDet = 1'b0;
        @(negedge clk);
        tick(2);
        rst = 1'b0;
        tick(1);
        test_reset();
        test_start_clear_stop();
        test_glitch();
        test_clear_collision();
        test_same_clk_and_repeated_start();
        test_back_to_back();
        test_reset_mid();
`ifdef I2C_BUS_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
